// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC sample/echo result types, widths and FSM encodings
//
// Purpose: types common to the AD9226 capture block and the echo detector.
//   ADC_SAMPLE_t  : one converter sample {otr, d}
//   ECHO_RESULT_t : per-record detector results
//   ECHO_STATE_e  : detector FSM state encoding (plain constants, legacy-compatible)
//   rectify()     : |d - baseline| on unsigned codes
package adc_pkg;

   localparam int ADC_SAMPLE_W  = 12;
   localparam int ECHO_WIN_LOG2 = 3;
   localparam int ECHO_IDX_W    = 10;

   typedef struct packed {
      logic                    otr;
      logic [ADC_SAMPLE_W-1:0] d;
   } ADC_SAMPLE_t;

   typedef struct packed {
      logic                    found;
      logic [ECHO_IDX_W-1:0]   first_idx;
      logic [ECHO_IDX_W-1:0]   peak_idx;
      logic [ADC_SAMPLE_W-1:0] peak_val;
      logic [ECHO_IDX_W-1:0]   otr_cnt;
   } ECHO_RESULT_t;

   typedef logic [1:0] ECHO_STATE_e;

   localparam ECHO_STATE_e ST_IDLE  = 2'd0;
   localparam ECHO_STATE_e ST_RUN   = 2'd1;
   localparam ECHO_STATE_e ST_DRAIN = 2'd2;
   localparam ECHO_STATE_e ST_DONE  = 2'd3;

   // One extra bit holds the signed difference of two unsigned codes; the
   // magnitude of that difference never exceeds full scale, so it fits back
   // into ADC_SAMPLE_W bits.
   function automatic logic [ADC_SAMPLE_W-1:0] rectify(
      input logic [ADC_SAMPLE_W-1:0] d,
      input logic [ADC_SAMPLE_W-1:0] base
   );
      logic signed [ADC_SAMPLE_W:0] diff;
      logic signed [ADC_SAMPLE_W:0] neg;
      diff = $signed({1'b0, d}) - $signed({1'b0, base});
      neg  = -diff;
      return diff[ADC_SAMPLE_W] ? neg[ADC_SAMPLE_W-1:0] : diff[ADC_SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/adc_echo_detect_if.sv
// rtl/adc_echo_detect_if.sv - ADC sample stream interface into the echo detector
//
// Purpose: groups the sample stream of one ping record.
//   tvalid : tdata valid this cycle
//   tlast  : final sample of the record (qualified by tvalid)
//   tdata  : ADC_SAMPLE_t {otr, d}
// There is no back-pressure; the converter free-runs.
// Modports: master (capture side drives), slave (detector consumes).
interface adc_echo_detect_if;
   import adc_pkg::*;

   logic        tvalid;
   logic        tlast;
   ADC_SAMPLE_t tdata;

   modport master (output tvalid, output tlast, output tdata);
   modport slave  (input  tvalid, input  tlast, input  tdata);

endinterface

// File: rtl/adc_moving_sum.sv
// rtl/adc_moving_sum.sv - sliding-window running sum producing the echo envelope
//
// Purpose: keeps the last 2**WIN_LOG2 magnitudes in a shift register and a
// running sum; env_o is the window mean (truncated).
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   clear_i          : synchronous clear of window, sum and fill count
//   in_valid_i       : in_mag_i carries a new magnitude
//   in_mag_i         : rectified magnitude
//   env_o            : sum >> WIN_LOG2, valid when env_valid_o
//   env_valid_o      : registered; high for a sample that completed a full window
module adc_moving_sum #(
   parameter int SAMPLE_W = 12,
   parameter int WIN_LOG2 = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   input  logic                in_valid_i,
   input  logic [SAMPLE_W-1:0] in_mag_i,
   output logic [SAMPLE_W-1:0] env_o,
   output logic                env_valid_o
);

   localparam int WIN   = 2**WIN_LOG2;
   localparam int SUM_W = SAMPLE_W + WIN_LOG2;

   logic [SAMPLE_W-1:0] r_win [WIN];
   logic [SUM_W-1:0]    r_sum;
   // Saturates at WIN-1: once that many samples are in, the next one fills the window.
   logic [WIN_LOG2-1:0] r_fill;
   logic                r_env_valid;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         for (int i = 0; i < WIN; i++) begin
            r_win[i] <= '0;
         end
         r_sum       <= '0;
         r_fill      <= '0;
         r_env_valid <= 1'b0;
      end else begin
         r_env_valid <= in_valid_i && (r_fill == '1);
         if (in_valid_i) begin
            // Window starts zeroed, so subtracting the oldest entry is exact
            // even before the window is full.
            r_sum    <= r_sum + SUM_W'(in_mag_i) - SUM_W'(r_win[WIN-1]);
            r_win[0] <= in_mag_i;
            for (int i = 1; i < WIN; i++) begin
               r_win[i] <= r_win[i-1];
            end
            if (r_fill != '1) begin
               r_fill <= r_fill + 1'b1;
            end
         end
      end
   end

   assign env_o       = r_sum[SUM_W-1:WIN_LOG2];
   assign env_valid_o = r_env_valid;

endmodule

// File: rtl/adc_echo_detect.sv
// rtl/adc_echo_detect.sv - per-record echo detector: envelope, first crossing, peak, OTR count
//
// Purpose: consumes one ping record, builds a rectified moving-average
// envelope around baseline_i and holds the record results for the CSR layer.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : 1-cycle pulse, abort/clear and begin a new record
//   s_sample       : sample stream (slave)
//   baseline_i     : code subtracted before rectification
//   threshold_i    : envelope crossing level
//   holdoff_i      : indices below this never count as a crossing
//   busy_o, done_o : record in progress / results valid (level)
//   found_o, first_idx_o, peak_idx_o, peak_val_o, otr_cnt_o : results
// Pipeline: accept -> rectify (reg) -> moving sum (reg) -> results (reg);
// done_o rises together with the final result update.
module adc_echo_detect
   import adc_pkg::*;
#(
   parameter int SAMPLE_W = ADC_SAMPLE_W,
   parameter int WIN_LOG2 = ECHO_WIN_LOG2,
   parameter int IDX_W    = ECHO_IDX_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   adc_echo_detect_if.slave    s_sample,
   input  logic [SAMPLE_W-1:0] baseline_i,
   input  logic [SAMPLE_W-1:0] threshold_i,
   input  logic [IDX_W-1:0]    holdoff_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                found_o,
   output logic [IDX_W-1:0]    first_idx_o,
   output logic [IDX_W-1:0]    peak_idx_o,
   output logic [SAMPLE_W-1:0] peak_val_o,
   output logic [IDX_W-1:0]    otr_cnt_o
);

   ECHO_STATE_e         r_state;
   logic                r_drain_cnt;
   logic [IDX_W-1:0]    r_idx;

   logic                r_s1_valid;
   logic [SAMPLE_W-1:0] r_s1_mag;
   logic [IDX_W-1:0]    r_s1_idx;
   logic [IDX_W-1:0]    r_s2_idx;

   ECHO_RESULT_t        r_res;

   logic                w_accept;
   logic                w_last;
   logic [SAMPLE_W-1:0] w_env;
   logic                w_env_valid;

   // A sample coinciding with start_i belongs to the aborted record.
   assign w_accept = s_sample.tvalid && (r_state == ST_RUN) && !start_i;
   // The final index position closes the record even without tlast.
   assign w_last   = s_sample.tlast || (r_idx == '1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_drain_cnt <= 1'b0;
      end else if (start_i) begin
         r_state     <= ST_RUN;
         r_drain_cnt <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_accept && w_last) begin
                  r_state     <= ST_DRAIN;
                  r_drain_cnt <= 1'b0;
               end
            end
            ST_DRAIN: begin
               // Two cycles lets the last sample clear the moving sum and result stages.
               if (r_drain_cnt) begin
                  r_state <= ST_DONE;
               end else begin
                  r_drain_cnt <= 1'b1;
               end
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   // Stage 1: index and rectified magnitude.
   always_ff @(posedge clk_i) begin
      if (rst_i || start_i) begin
         r_idx      <= '0;
         r_s1_valid <= 1'b0;
         r_s1_mag   <= '0;
         r_s1_idx   <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_idx    <= r_idx + 1'b1;
            r_s1_idx <= r_idx;
            r_s1_mag <= s_sample.tdata.otr ? '1 : rectify(s_sample.tdata.d, baseline_i);
         end
      end
   end

   // Stage 2: envelope; the index tag travels alongside the running sum.
   adc_moving_sum #(
      .SAMPLE_W (SAMPLE_W),
      .WIN_LOG2 (WIN_LOG2)
   ) u_moving_sum (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (start_i),
      .in_valid_i  (r_s1_valid),
      .in_mag_i    (r_s1_mag),
      .env_o       (w_env),
      .env_valid_o (w_env_valid)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i || start_i) begin
         r_s2_idx <= '0;
      end else if (r_s1_valid) begin
         r_s2_idx <= r_s1_idx;
      end
   end

   // Stage 3: results. The OTR count is taken at accept time, not from the pipeline.
   always_ff @(posedge clk_i) begin
      if (rst_i || start_i) begin
         r_res <= '0;
      end else begin
         if (w_accept && s_sample.tdata.otr && (r_res.otr_cnt != '1)) begin
            r_res.otr_cnt <= r_res.otr_cnt + 1'b1;
         end
         if (w_env_valid) begin
            if (!r_res.found && (w_env >= threshold_i) && (r_s2_idx >= holdoff_i)) begin
               r_res.found     <= 1'b1;
               r_res.first_idx <= r_s2_idx;
            end
            // Strict compare keeps the earliest index on a tie.
            if (w_env > r_res.peak_val) begin
               r_res.peak_val <= w_env;
               r_res.peak_idx <= r_s2_idx;
            end
         end
      end
   end

   assign busy_o      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign done_o      = (r_state == ST_DONE);
   assign found_o     = r_res.found;
   assign first_idx_o = r_res.first_idx;
   assign peak_idx_o  = r_res.peak_idx;
   assign peak_val_o  = r_res.peak_val;
   assign otr_cnt_o   = r_res.otr_cnt;

endmodule

// File: tb/tb_adc_echo_detect.sv
// tb/tb_adc_echo_detect.sv - table-driven directed bench for adc_echo_detect
module tb_adc_echo_detect;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] baseline;
   logic [11:0] threshold;
   logic [9:0]  holdoff;
   logic        busy, done, found;
   logic [9:0]  first_idx, peak_idx, otr_cnt;
   logic [11:0] peak_val;

   always #5 clk = ~clk;

   adc_echo_detect_if sif();

   adc_echo_detect dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .s_sample    (sif),
      .baseline_i  (baseline),
      .threshold_i (threshold),
      .holdoff_i   (holdoff),
      .busy_o      (busy),
      .done_o      (done),
      .found_o     (found),
      .first_idx_o (first_idx),
      .peak_idx_o  (peak_idx),
      .peak_val_o  (peak_val),
      .otr_cnt_o   (otr_cnt)
   );

   typedef struct {
      int n;
      int base;
      int thr;
      int hold;
      int b_lo;
      int b_hi;
      int b_d;
      int o_lo;
      int o_hi;
      bit use_last;
      int e_found;
      int e_first;
      int e_pidx;
      int e_pval;
      int e_otr;
   } vec_t;

   vec_t tbl [11];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic drive(input bit v, input bit l, input bit o, input int dv);
      sif.tvalid    = v;
      sif.tlast     = l;
      sif.tdata.otr = o;
      sif.tdata.d   = 12'(dv);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_record(input int k, input vec_t v);
      int lat;
      int dv;
      baseline  = 12'(v.base);
      threshold = 12'(v.thr);
      holdoff   = 10'(v.hold);
      drive(0, 0, 0, 0);
      pulse_start();
      chk($sformatf("r%0d busy_after_start", k), int'({busy, done}), 2);
      for (int i = 0; i < v.n; i++) begin
         dv = (i >= v.b_lo && i <= v.b_hi) ? v.b_d : v.base;
         drive(1, v.use_last && (i == v.n - 1), (i >= v.o_lo && i <= v.o_hi), dv);
         @(negedge clk);
      end
      drive(0, 0, 0, 0);
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("r%0d done_latency", k), lat, 3);
      chk($sformatf("r%0d busy", k), int'(busy), 0);
      chk($sformatf("r%0d found", k), int'(found), v.e_found);
      chk($sformatf("r%0d first_idx", k), int'(first_idx), v.e_first);
      chk($sformatf("r%0d peak_idx", k), int'(peak_idx), v.e_pidx);
      chk($sformatf("r%0d peak_val", k), int'(peak_val), v.e_pval);
      chk($sformatf("r%0d otr_cnt", k), int'(otr_cnt), v.e_otr);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      //          n   base  thr  hold lo   hi    d    olo ohi last  fnd first pidx pval otr
      tbl[0]  = '{64, 2048, 100, 0,   1,   0,    2048, 1,  0,  1,   0,  0,    0,   0,   0};
      tbl[1]  = '{64, 2048, 450, 0,   30,  45,   2548, 1,  0,  1,   1,  37,   37,  500, 0};
      tbl[2]  = '{64, 2048, 400, 0,   30,  45,   2548, 1,  0,  1,   1,  36,   37,  500, 0};
      tbl[3]  = '{64, 2048, 450, 40,  30,  45,   2548, 1,  0,  1,   1,  40,   37,  500, 0};
      tbl[4]  = '{64, 2048, 450, 50,  30,  45,   2548, 1,  0,  1,   0,  0,    37,  500, 0};
      tbl[5]  = '{64, 2048, 450, 0,   30,  45,   1548, 1,  0,  1,   1,  37,   37,  500, 0};
      tbl[6]  = '{64, 2048, 4095,0,   1,   0,    2048, 10, 12, 1,   0,  0,    12,  1535,3};
      tbl[7]  = '{5,  2048, 0,   0,   1,   0,    2048, 1,  0,  1,   0,  0,    0,   0,   0};
      tbl[8]  = '{1024,2048,450, 0,   1000,1015, 2548, 1,  0,  0,   1,  1007, 1007,500, 0};
      tbl[9]  = '{8,  2048, 500, 7,   0,   7,    2548, 1,  0,  1,   1,  7,    7,   500, 0};
      tbl[10] = '{64, 1000, 600, 0,   30,  45,   1600, 1,  0,  1,   1,  37,   37,  600, 0};

      rst = 1'b1;
      start = 1'b0;
      baseline = 12'd2048;
      threshold = 12'd100;
      holdoff = 10'd0;
      drive(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset found", int'(found), 0);
      chk("reset first_idx", int'(first_idx), 0);
      chk("reset peak", int'(peak_val) + int'(peak_idx), 0);
      chk("reset otr_cnt", int'(otr_cnt), 0);

      // Samples in IDLE are ignored.
      for (int i = 0; i < 5; i++) begin
         drive(1, i == 4, 1, 4095);
         @(negedge clk);
      end
      drive(0, 0, 0, 0);
      repeat (4) @(negedge clk);
      chk("idle ignore otr_cnt", int'(otr_cnt), 0);
      chk("idle ignore state", int'({busy, done}), 0);

      for (int k = 0; k < 11; k++) begin
         run_record(k, tbl[k]);
      end

      // Samples in DONE are ignored; results hold.
      for (int i = 0; i < 10; i++) begin
         drive(1, i == 9, 1, 4095);
         @(negedge clk);
      end
      drive(0, 0, 0, 0);
      repeat (4) @(negedge clk);
      chk("done hold done", int'(done), 1);
      chk("done hold otr_cnt", int'(otr_cnt), 0);
      chk("done hold peak_val", int'(peak_val), 600);

      // Abort at idx 20; the same-cycle sample must not reach the new record.
      baseline = 12'd2048;
      threshold = 12'd450;
      holdoff = 10'd0;
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 1, 4095);
         @(negedge clk);
      end
      chk("abort pre otr_cnt", int'(otr_cnt), 20);
      drive(1, 0, 1, 4095);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("abort cleared otr_cnt", int'(otr_cnt), 0);
      chk("abort state", int'({busy, done}), 2);
      for (int i = 0; i < 64; i++) begin
         drive(1, i == 63, 0, (i >= 30 && i <= 45) ? 2548 : 2048);
         @(negedge clk);
      end
      drive(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("abort new done", int'(done), 1);
      chk("abort new first_idx", int'(first_idx), 37);
      chk("abort new peak_idx", int'(peak_idx), 37);
      chk("abort new otr_cnt", int'(otr_cnt), 0);

      // Reset mid-record clears everything on the next cycle.
      pulse_start();
      for (int i = 0; i < 40; i++) begin
         drive(1, 0, i < 3, (i >= 30) ? 2548 : 2048);
         @(negedge clk);
      end
      chk("pre-reset found", int'(found), 1);
      chk("pre-reset otr_cnt", int'(otr_cnt), 3);
      rst = 1'b1;
      @(negedge clk);
      chk("mid reset state", int'({busy, done}), 0);
      chk("mid reset found", int'(found), 0);
      chk("mid reset results", int'(first_idx) + int'(peak_idx) + int'(peak_val) + int'(otr_cnt), 0);
      rst = 1'b0;
      drive(0, 0, 0, 0);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
